// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the imem boot loader: FSM states, frame magic,
// default imem depth and the word-to-byte-address helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    PAYLOAD,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [15:0] idx
  );
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream handshake: valid/data from the producer, ready back.
// master = byte producer, slave = byte consumer.
interface imem_boot_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: packs 4 bytes (LSB first) into a 32-bit word.
// Ports: i_clk, i_resetn, s_byte (slave), o_word_valid pulse, o_word.
module byte_word_packer (
  input  logic              i_clk,
  input  logic              i_resetn,
  imem_boot_loader_if.slave s_byte,
  output logic              o_word_valid,
  output logic [31:0]       o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_sh;

  assign s_byte.ready = 1'b1;

  // Word completes combinationally on the 4th byte;
  // the caller registers it.
  assign o_word_valid = s_byte.valid && (r_idx == 2'd3);
  assign o_word       = {s_byte.data, r_sh};

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_idx <= 2'd0;
      r_sh  <= 24'd0;
    end else if (s_byte.valid) begin
      r_idx <= r_idx + 2'd1;
      r_sh  <= {s_byte.data, r_sh[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte stream -> imem word writes, holds core in
// reset until a checksum-clean frame lands. Ports: byte link, imem wr, status.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  MAGIC       = LOADER_MAGIC
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_resetn,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded
);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [7:0]  r_cnt_lo;
  logic [15:0] r_cnt;
  logic [15:0] r_widx;
  logic [7:0]  r_xor;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_core_rstn;

  logic        w_acc;
  logic        w_magic;
  logic        w_pay;
  logic        w_clr;
  logic [15:0] w_cnt;
  logic        w_cnt_big;
  logic        w_last;
  logic        w_set_done;
  logic        w_word_valid;
  logic [31:0] w_word;

  imem_boot_loader_if u_lnk ();

  byte_word_packer u_pack (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .s_byte       (u_lnk),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Ready is gated by reset so every output sits at 0 while held.
  assign o_byte_ready = i_resetn
                     && (r_state != DONE)
                     && ((r_state != PAYLOAD) || u_lnk.ready);

  assign w_acc   = i_byte_valid && o_byte_ready;
  assign w_magic = w_acc && (i_byte == MAGIC);
  assign w_pay   = w_acc && (r_state == PAYLOAD);
  assign w_clr   = w_magic
                && ((r_state == IDLE) || (r_state == ERROR));

  assign u_lnk.valid = w_pay;
  assign u_lnk.data  = i_byte;

  assign w_cnt     = {i_byte, r_cnt_lo};
  assign w_cnt_big = 32'(w_cnt) > DEPTH_WORDS;
  assign w_last    = w_word_valid && ((r_widx + 16'd1) == r_cnt);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    unique case (r_state)
      IDLE, ERROR: begin
        if (w_magic) w_next = CNT_LO;
      end
      CNT_LO: begin
        if (w_acc) w_next = CNT_HI;
      end
      CNT_HI: begin
        if (w_acc) begin
          if (w_cnt_big)          w_next = ERROR;
          else if (w_cnt == 16'd0) w_next = CHK;
          else                     w_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_last) w_next = CHK;
      end
      CHK: begin
        if (w_acc) begin
          if (i_byte == r_xor) begin
            w_next     = DONE;
            w_set_done = 1'b1;
          end else begin
            w_next = ERROR;
          end
        end
      end
      DONE: begin
        w_next = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt_lo    <= 8'd0;
      r_cnt       <= 16'd0;
      r_widx      <= 16'd0;
      r_xor       <= 8'd0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= 32'd0;
      r_done      <= 1'b0;
      r_core_rstn <= 1'b0;
    end else begin
      r_we <= w_word_valid;
      if (w_clr) begin
        r_widx <= 16'd0;
        r_xor  <= 8'd0;
      end else begin
        if (w_pay)        r_xor  <= r_xor ^ i_byte;
        if (w_word_valid) r_widx <= r_widx + 16'd1;
      end
      if (w_word_valid) begin
        r_addr  <= word_addr(BASE_ADDR, r_widx);
        r_wdata <= w_word;
      end
      if (w_acc && (r_state == CNT_LO)) r_cnt_lo <= i_byte;
      if (w_acc && (r_state == CNT_HI)) r_cnt    <= w_cnt;
      // Core reset is a flop so the cpu never sees a glitch.
      if (w_set_done) begin
        r_done      <= 1'b1;
        r_core_rstn <= 1'b1;
      end
    end
  end

  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_core_resetn  = r_core_rstn;
  assign o_done         = r_done;
  assign o_error        = (r_state == ERROR);
  assign o_words_loaded = r_widx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: scoreboarded imem writes,
// per-scenario tasks for framing, checksum, size limits, stalls, reset.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [7:0]  MAG  = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_core_resetn;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words_loaded;

  imem_boot_loader_if u_if ();

  imem_boot_loader dut (
    .i_clk          (clk),
    .i_resetn       (rst_n),
    .i_byte_valid   (u_if.valid),
    .i_byte         (u_if.data),
    .o_byte_ready   (u_if.ready),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wdata   (o_imem_wdata),
    .o_core_resetn  (o_core_resetn),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_writes = 0;
  logic [63:0] sb_q[$];
  logic [31:0] frame_q[$];
  logic [7:0]  last_x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (o_imem_we === 1'b1) begin
      logic [63:0] exp;
      n_writes++;
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL wr_unexpected addr=%h data=%h", o_imem_addr, o_imem_wdata);
      end else begin
        exp = sb_q.pop_front();
        if ({o_imem_addr, o_imem_wdata} !== exp)
          $display("FAIL wr_data got %h_%h need %h_%h",
                   o_imem_addr, o_imem_wdata, exp[63:32], exp[31:0]);
        else n_pass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit acc;
    int n;
    int g;
    acc = 1'b0;
    n = 0;
    g = 0;
    if (stall) begin
      while ($urandom_range(0, 1) == 1 && g < 4) begin
        @(negedge clk);
        g++;
      end
    end
    while (!acc && n < 20) begin
      @(negedge clk);
      u_if.valid = 1'b1;
      u_if.data  = b;
      #1 acc = u_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    u_if.valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout byte=%h ready=%b need 1", b, u_if.ready);
    end
  endtask

  task automatic send_frame(input int cnt, input int nsend,
                            input bit bad, input bit stall,
                            input bit with_chk);
    logic [7:0]  x;
    logic [15:0] c;
    logic [31:0] w;
    x = 8'd0;
    c = cnt[15:0];
    send_byte(MAG, stall);
    send_byte(c[7:0], stall);
    send_byte(c[15:8], stall);
    for (int i = 0; i < nsend; i++) begin
      w = frame_q[i];
      sb_q.push_back({BASE + 32'(i) * 32'd4, w});
      for (int k = 0; k < 4; k++) begin
        x ^= w[8*k +: 8];
        send_byte(w[8*k +: 8], stall);
      end
    end
    last_x = x;
    if (with_chk) send_byte(x ^ (bad ? 8'h01 : 8'h00), stall);
  endtask

  task automatic do_reset();
    @(negedge clk);
    u_if.valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.valid = 1'b0;
    u_if.data = 8'h00;
    repeat (2) @(negedge clk);
    n_total++;
    if ({o_core_resetn, o_done, o_error, o_imem_we} !== 4'b0000)
      $display("FAIL rst_flags got %b need 0000",
               {o_core_resetn, o_done, o_error, o_imem_we});
    else n_pass++;
    n_total++;
    if (o_imem_addr !== BASE) $display("FAIL rst_addr got %h need %h", o_imem_addr, BASE);
    else n_pass++;
    n_total++;
    if ({o_imem_wdata, o_words_loaded} !== 48'd0)
      $display("FAIL rst_data got %h/%h need 0", o_imem_wdata, o_words_loaded);
    else n_pass++;
    n_total++;
    if (u_if.ready !== 1'b0) $display("FAIL rst_ready got %b need 0", u_if.ready);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (u_if.ready !== 1'b1) $display("FAIL idle_ready got %b need 1", u_if.ready);
    else n_pass++;
  endtask

  task automatic test_regression_load();
    int w0;
    do_reset();
    w0 = n_writes;
    frame_q.delete();
    for (int i = 0; i < 22; i++)
      frame_q.push_back(32'h0010_0093 ^ (32'(i) << 7) ^ (32'(i) << 20));
    send_frame(22, 22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if ({o_core_resetn, o_done} !== 2'b00)
      $display("FAIL pre_chk got %b need 00", {o_core_resetn, o_done});
    else n_pass++;
    send_byte(last_x, 1'b0);
    n_total++;
    if ({o_core_resetn, o_done, o_error} !== 3'b110)
      $display("FAIL reg_done got %b need 110", {o_core_resetn, o_done, o_error});
    else n_pass++;
    n_total++;
    if (n_writes - w0 != 22 || sb_q.size() != 0)
      $display("FAIL reg_writes got %0d need 22", n_writes - w0);
    else n_pass++;
    n_total++;
    if (o_words_loaded !== 16'd22) $display("FAIL reg_words got %0d need 22", o_words_loaded);
    else n_pass++;
    @(negedge clk);
    u_if.valid = 1'b1;
    u_if.data = MAG;
    #1;
    n_total++;
    if (u_if.ready !== 1'b0) $display("FAIL done_ready got %b need 0", u_if.ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    u_if.valid = 1'b0;
    n_total++;
    if ({o_done, o_words_loaded} !== {1'b1, 16'd22})
      $display("FAIL done_hold got %b/%0d need 1/22", o_done, o_words_loaded);
    else n_pass++;
  endtask

  task automatic test_resync();
    int w0;
    do_reset();
    w0 = n_writes;
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    frame_q.delete();
    frame_q.push_back(32'hDEAD_BEEF);
    send_frame(1, 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if ({o_done, o_core_resetn} !== 2'b11 || n_writes - w0 != 1 || sb_q.size() != 0)
      $display("FAIL resync got done=%b wr=%0d need 1/1", o_done, n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    do_reset();
    frame_q.delete();
    frame_q.push_back(32'hDEAD_BEEF);
    send_frame(1, 1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if ({o_error, o_done, o_core_resetn} !== 3'b100)
      $display("FAIL bad_chk got %b need 100", {o_error, o_done, o_core_resetn});
    else n_pass++;
    frame_q.delete();
    frame_q.push_back(32'h1234_5678);
    frame_q.push_back(32'hA5A5_0000);
    send_frame(2, 2, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (o_error !== 1'b0) $display("FAIL err_clear got %b need 0", o_error);
    else n_pass++;
    send_byte(last_x, 1'b0);
    @(negedge clk);
    n_total++;
    if ({o_error, o_done, o_core_resetn} !== 3'b011 || sb_q.size() != 0)
      $display("FAIL recover got %b need 011", {o_error, o_done, o_core_resetn});
    else n_pass++;
  endtask

  task automatic test_size_limits();
    int w0;
    do_reset();
    w0 = n_writes;
    send_byte(MAG, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    n_total++;
    if ({o_error, o_done} !== 2'b10 || o_words_loaded !== 16'd0)
      $display("FAIL oversize got %b/%0d need 10/0", {o_error, o_done}, o_words_loaded);
    else n_pass++;
    frame_q.delete();
    send_frame(0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if ({o_error, o_done, o_core_resetn} !== 3'b011 || n_writes != w0)
      $display("FAIL zero_frame got %b wr=%0d need 011/0",
               {o_error, o_done, o_core_resetn}, n_writes - w0);
    else n_pass++;
    do_reset();
    w0 = n_writes;
    frame_q.delete();
    for (int i = 0; i < 256; i++) frame_q.push_back($urandom);
    send_frame(256, 256, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b1 || n_writes - w0 != 256 || sb_q.size() != 0)
      $display("FAIL full_depth got done=%b wr=%0d need 1/256", o_done, n_writes - w0);
    else n_pass++;
    n_total++;
    if (o_imem_addr !== 32'h0000_03FC || o_words_loaded !== 16'd256)
      $display("FAIL full_last got %h/%0d need 3fc/256", o_imem_addr, o_words_loaded);
    else n_pass++;
  endtask

  task automatic test_stall();
    int w0;
    do_reset();
    w0 = n_writes;
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back($urandom);
    send_frame(4, 4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_total++;
    if (o_done !== 1'b1 || n_writes - w0 != 4 || sb_q.size() != 0)
      $display("FAIL stall got done=%b wr=%0d need 1/4", o_done, n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_midload_reset();
    int w0;
    do_reset();
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(32'hC0DE_0000 + 32'(i));
    send_frame(4, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (o_words_loaded !== 16'd2 || sb_q.size() != 0)
      $display("FAIL mid_words got %0d need 2", o_words_loaded);
    else n_pass++;
    w0 = n_writes;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_core_resetn, o_done, o_error, o_imem_we, u_if.ready} !== 5'b00000)
      $display("FAIL mid_rst_flags got %b need 00000",
               {o_core_resetn, o_done, o_error, o_imem_we, u_if.ready});
    else n_pass++;
    n_total++;
    if ({o_imem_addr, o_imem_wdata, o_words_loaded} !== {BASE, 32'd0, 16'd0})
      $display("FAIL mid_rst_vals got %h/%h/%0d need %h/0/0",
               o_imem_addr, o_imem_wdata, o_words_loaded, BASE);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_total++;
    if (n_writes != w0) $display("FAIL mid_no_we got %0d need 0", n_writes - w0);
    else n_pass++;
    send_frame(4, 4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_total++;
    if ({o_done, o_core_resetn} !== 2'b11 || n_writes - w0 != 4 || sb_q.size() != 0)
      $display("FAIL reload got done=%b wr=%0d need 1/4", o_done, n_writes - w0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_regression_load();
    test_resync();
    test_bad_chk();
    test_size_limits();
    test_stall();
    test_midload_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
